// File: rtl/alu_issue_queue.sv
// Circular-FIFO issue queue feeding a single ALU; IDLE/ISSUE/WAIT issue FSM with per-instruction timeout.
// Optional completed-issue counter on port `issued` when ALU_ISSUE_STATS_EN is defined.
module alu_issue_queue #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [47:0] in_inst,
   output logic        alu_en,
   output logic [47:0] alu_inst,
   input  logic        alu_done,
   output logic [3:0]  count,
   output logic        busy,
   output logic        drop,
   output logic        err
`ifdef ALU_ISSUE_STATS_EN
   ,
   output logic [15:0] issued
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] DEPTH_C = 4'(DEPTH);
   localparam logic [7:0] TMO     = 8'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t        state, state_nxt;
   logic [47:0]   mem [DEPTH];
   logic [AW-1:0] head, tail;
   logic [7:0]    wcnt, wcnt_nxt;
   logic [3:0]    count_nxt;
   logic          accept, push, pop, tmo;

   // Gated by reset so the upstream sees not-ready for the whole reset window.
   assign in_ready = rst && (count < DEPTH_C);
   assign accept   = in_valid && in_ready;
   assign push     = accept && (in_inst[2:0] == 3'b100);
   assign alu_en   = (state != IDLE);
   assign alu_inst = alu_en ? mem[head] : 48'h0;
   assign busy     = (count != 4'd0) || alu_en;

   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      pop       = 1'b0;
      tmo       = 1'b0;
      case (state)
         IDLE:  if (count != 4'd0) state_nxt = ISSUE;
         ISSUE: begin
            if (alu_done) pop = 1'b1;
            else begin
               state_nxt = WAIT;
               wcnt_nxt  = 8'd1;
            end
         end
         WAIT: begin
            if (alu_done) pop = 1'b1;
            else if (({1'b0, wcnt} + 9'd1) >= {1'b0, TMO}) begin
               pop       = 1'b1;
               tmo       = 1'b1;
               state_nxt = IDLE;
               wcnt_nxt  = 8'd0;
            end else wcnt_nxt = wcnt + 8'd1;
         end
         default: state_nxt = IDLE;
      endcase
      count_nxt = count + {3'b000, push} - {3'b000, pop};
      // A completed pop re-issues immediately if anything (including this edge's push) remains.
      if (pop && !tmo) begin
         state_nxt = (count_nxt != 4'd0) ? ISSUE : IDLE;
         wcnt_nxt  = 8'd0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         head  <= '0;
         tail  <= '0;
         count <= 4'd0;
         wcnt  <= 8'd0;
         drop  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
         count <= count_nxt;
         drop  <= accept && !push;
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         if (tmo)  err  <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[tail] <= in_inst;
   end

`ifdef ALU_ISSUE_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) issued <= 16'h0;
      else if (pop && !tmo && (issued != 16'hFFFF)) issued <= issued + 16'd1;
   end
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: directed scenarios plus randomized traffic vs a queue-level model.
module tb_alu_issue_queue;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 3;

   logic        clk, rst, in_valid, in_ready, alu_en, alu_done, busy, drop, err;
   logic [47:0] in_inst, alu_inst;
   logic [3:0]  count;
`ifdef ALU_ISSUE_STATS_EN
   logic [15:0] issued;
`endif

   alu_issue_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
      .alu_en(alu_en), .alu_inst(alu_inst), .alu_done(alu_done), .count(count),
      .busy(busy), .drop(drop), .err(err)
`ifdef ALU_ISSUE_STATS_EN
      , .issued(issued)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   // Reference model: a plain queue of pending words, whether the head is on the ALU,
   // and how many cycles it has been presented without completing.
   logic [47:0] mq[$];
   bit          m_active, m_drop, m_err;
   int          m_elapsed;
   logic [15:0] m_issued;

   task automatic model_reset();
      mq.delete();
      m_active = 0; m_drop = 0; m_err = 0; m_elapsed = 0; m_issued = 16'h0;
   endtask

   task automatic model_update();
      int sz;
      bit acc, popq, to;
      if (!rst) begin
         model_reset();
         return;
      end
      sz   = mq.size();
      acc  = in_valid && (sz < DEPTH);
      popq = 0;
      to   = 0;
      if (m_active) begin
         if (alu_done) popq = 1;
         else if (m_elapsed > 0 && m_elapsed + 1 >= TIMEOUT) begin popq = 1; to = 1; end
      end
      m_drop = acc && (in_inst[2:0] != 3'b100);
      if (popq) void'(mq.pop_front());
      if (acc && in_inst[2:0] == 3'b100) mq.push_back(in_inst);
      if (to) m_err = 1;
      if (popq && !to && m_issued != 16'hFFFF) m_issued = m_issued + 16'd1;
      if (!m_active) begin
         m_active  = (sz > 0);
         m_elapsed = 0;
      end else if (popq) begin
         m_active  = !to && (mq.size() > 0);
         m_elapsed = 0;
      end else m_elapsed++;
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
   endtask

   function automatic logic [47:0] mk_alu();
      logic [47:0] w;
      w      = {$urandom(), 16'($urandom())};
      w[2:0] = 3'b100;
      return w;
   endfunction

   task automatic test_reset();
      rst = 1'b0; in_valid = 1'b0; in_inst = '0; alu_done = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL reset_in_ready: got %b exp 0", in_ready); end
      nvec++; if (alu_en !== 1'b0) begin nerr++; $display("FAIL reset_alu_en: got %b exp 0", alu_en); end
      nvec++; if (alu_inst !== 48'h0) begin nerr++; $display("FAIL reset_alu_inst: got %h exp 0", alu_inst); end
      nvec++; if (count !== 4'd0) begin nerr++; $display("FAIL reset_count: got %0d exp 0", count); end
      nvec++; if ({busy, drop, err} !== 3'b000) begin nerr++; $display("FAIL reset_flags: got %b exp 000", {busy, drop, err}); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL release_in_ready: got %b exp 1", in_ready); end
   endtask

   task automatic test_single();
      logic [47:0] w;
      w = 48'h0000_0005_2184;
      in_valid = 1'b1; in_inst = w; alu_done = 1'b1;
      step();
      in_valid = 1'b0;
      nvec++; if (alu_en !== 1'b0) begin nerr++; $display("FAIL single_early: got alu_en %b exp 0", alu_en); end
      nvec++; if (count !== 4'd1) begin nerr++; $display("FAIL single_count1: got %0d exp 1", count); end
      step();
      nvec++; if (alu_en !== 1'b1) begin nerr++; $display("FAIL single_en: got %b exp 1", alu_en); end
      nvec++; if (alu_inst !== w) begin nerr++; $display("FAIL single_inst: got %h exp %h", alu_inst, w); end
      step();
      nvec++; if (alu_en !== 1'b0) begin nerr++; $display("FAIL single_one_cycle: got alu_en %b exp 0", alu_en); end
      nvec++; if (count !== 4'd0) begin nerr++; $display("FAIL single_count0: got %0d exp 0", count); end
`ifdef ALU_ISSUE_STATS_EN
      nvec++; if (issued !== 16'd1) begin nerr++; $display("FAIL single_issued: got %0d exp 1", issued); end
`endif
   endtask

   task automatic test_drop();
      in_valid = 1'b1; in_inst = 48'h0000_0000_0003; alu_done = 1'b0;
      step();
      in_valid = 1'b0;
      nvec++; if (drop !== 1'b1) begin nerr++; $display("FAIL drop_pulse: got %b exp 1", drop); end
      nvec++; if (count !== 4'd0) begin nerr++; $display("FAIL drop_count: got %0d exp 0", count); end
      step();
      nvec++; if (drop !== 1'b0) begin nerr++; $display("FAIL drop_clear: got %b exp 0", drop); end
      nvec++; if (alu_en !== 1'b0) begin nerr++; $display("FAIL drop_no_issue: got %b exp 0", alu_en); end
   endtask

   task automatic test_full();
      logic [47:0] w[5];
      for (int i = 0; i < 5; i++) w[i] = mk_alu();
      alu_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_inst = w[i];
         step();
      end
      nvec++; if (count !== 4'd4) begin nerr++; $display("FAIL full_count: got %0d exp 4", count); end
      nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL full_ready: got %b exp 0", in_ready); end
      nvec++; if (alu_inst !== w[0]) begin nerr++; $display("FAIL full_head: got %h exp %h", alu_inst, w[0]); end
      in_inst = w[4]; alu_done = 1'b1;
      step();
      nvec++; if (count !== 4'd3) begin nerr++; $display("FAIL full_holdoff: got count %0d exp 3", count); end
      nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL full_ready_back: got %b exp 1", in_ready); end
      nvec++; if (alu_inst !== w[1]) begin nerr++; $display("FAIL full_pop1: got %h exp %h", alu_inst, w[1]); end
      step();
      in_valid = 1'b0;
      nvec++; if (count !== 4'd3) begin nerr++; $display("FAIL full_pushpop: got count %0d exp 3", count); end
      for (int k = 2; k < 5; k++) begin
         nvec++; if (alu_inst !== w[k]) begin nerr++; $display("FAIL full_order%0d: got %h exp %h", k, alu_inst, w[k]); end
         step();
      end
      nvec++; if ({alu_en, count} !== 5'd0) begin nerr++; $display("FAIL full_drain: got en %b count %0d exp 0 0", alu_en, count); end
      nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL full_err: got %b exp 0", err); end
   endtask

   task automatic test_back_to_back();
      logic [47:0] w[8];
      for (int i = 0; i < 8; i++) w[i] = mk_alu();
      alu_done = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = (i < 8);
         in_inst  = (i < 8) ? w[i] : 48'h0;
         step();
         if (i >= 1 && i <= 8) begin
            nvec++; if (alu_en !== 1'b1) begin nerr++; $display("FAIL b2b_en%0d: got %b exp 1", i, alu_en); end
            nvec++; if (alu_inst !== w[i-1]) begin nerr++; $display("FAIL b2b_inst%0d: got %h exp %h", i, alu_inst, w[i-1]); end
         end else begin
            nvec++; if (alu_en !== 1'b0) begin nerr++; $display("FAIL b2b_idle%0d: got %b exp 0", i, alu_en); end
         end
      end
      in_valid = 1'b0;
      nvec++; if (count !== 4'd0) begin nerr++; $display("FAIL b2b_count: got %0d exp 0", count); end
   endtask

   task automatic test_timeout();
      logic [47:0] w0, w1;
      w0 = mk_alu(); w1 = mk_alu();
      alu_done = 1'b0;
      in_valid = 1'b1; in_inst = w0;
      step();
      in_inst = w1;
      step();
      in_valid = 1'b0;
      nvec++; if (alu_inst !== w0) begin nerr++; $display("FAIL tmo_head: got %h exp %h", alu_inst, w0); end
      step(); step();
      nvec++; if ({alu_en, err} !== 2'b10) begin nerr++; $display("FAIL tmo_waiting: got en,err %b exp 10", {alu_en, err}); end
      step();
      nvec++; if ({alu_en, err} !== 2'b01) begin nerr++; $display("FAIL tmo_fire: got en,err %b exp 01", {alu_en, err}); end
      nvec++; if (count !== 4'd1) begin nerr++; $display("FAIL tmo_count: got %0d exp 1", count); end
      step();
      nvec++; if (alu_inst !== w1) begin nerr++; $display("FAIL tmo_next: got %h exp %h", alu_inst, w1); end
      alu_done = 1'b1;
      step();
      nvec++; if ({count, err} !== 5'b0000_1) begin nerr++; $display("FAIL tmo_sticky: got count %0d err %b exp 0 1", count, err); end
`ifdef ALU_ISSUE_STATS_EN
      nvec++; if (issued !== m_issued) begin nerr++; $display("FAIL tmo_issued: got %0d exp %0d", issued, m_issued); end
`endif
   endtask

   task automatic test_reset_mid();
      logic [47:0] w;
      alu_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_inst = mk_alu();
         step();
      end
      in_valid = 1'b0;
      nvec++; if ({alu_en, count} !== 5'b1_0011) begin nerr++; $display("FAIL rmid_pre: got en %b count %0d exp 1 3", alu_en, count); end
      #2 rst = 1'b0;
      #1;
      model_reset();
      nvec++; if (alu_en !== 1'b0) begin nerr++; $display("FAIL rmid_async_en: got %b exp 0", alu_en); end
      nvec++; if ({count, err, in_ready} !== 6'd0) begin nerr++; $display("FAIL rmid_clear: got count %0d err %b rdy %b exp 0", count, err, in_ready); end
      @(negedge clk);
      rst = 1'b1;
      w = mk_alu();
      in_valid = 1'b1; in_inst = w; alu_done = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      nvec++; if ({alu_en, alu_inst} !== {1'b1, w}) begin nerr++; $display("FAIL rmid_reissue: got %b %h exp 1 %h", alu_en, alu_inst, w); end
      step();
      nvec++; if ({alu_en, count} !== 5'd0) begin nerr++; $display("FAIL rmid_done: got en %b count %0d exp 0 0", alu_en, count); end
   endtask

   task automatic test_random();
      logic [47:0] exp_inst;
      for (int c = 0; c < 400; c++) begin
         in_valid = ($urandom_range(0, 1) == 1);
         in_inst  = mk_alu();
         if ($urandom_range(0, 3) == 0) in_inst[2:0] = 3'($urandom_range(0, 3));
         alu_done = ($urandom_range(0, 9) < 4);
         step();
         exp_inst = m_active ? mq[0] : 48'h0;
         nvec++; if (alu_en !== m_active) begin nerr++; $display("FAIL rnd_en c%0d: got %b exp %b", c, alu_en, m_active); end
         nvec++; if (alu_inst !== exp_inst) begin nerr++; $display("FAIL rnd_inst c%0d: got %h exp %h", c, alu_inst, exp_inst); end
         nvec++; if (count !== 4'(mq.size())) begin nerr++; $display("FAIL rnd_count c%0d: got %0d exp %0d", c, count, mq.size()); end
         nvec++; if (in_ready !== (mq.size() < DEPTH)) begin nerr++; $display("FAIL rnd_ready c%0d: got %b", c, in_ready); end
         nvec++; if (busy !== (m_active || mq.size() != 0)) begin nerr++; $display("FAIL rnd_busy c%0d: got %b", c, busy); end
         nvec++; if ({drop, err} !== {m_drop, m_err}) begin nerr++; $display("FAIL rnd_flags c%0d: got %b exp %b", c, {drop, err}, {m_drop, m_err}); end
`ifdef ALU_ISSUE_STATS_EN
         nvec++; if (issued !== m_issued) begin nerr++; $display("FAIL rnd_issued c%0d: got %0d exp %0d", c, issued, m_issued); end
`endif
      end
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_drop();
      test_full();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving queue entries; legal values 2, 4 or 8.
REQ-002 The block SHALL have parameter TIMEOUT, default 15, giving the maximum cycles to wait for alu_done per instruction; legal values 1 to 255.
REQ-003 The block SHALL use one clock and an asynchronous active-low reset: clk clocks all state; rst asserted low clears state immediately.
REQ-004 Ports SHALL be as follows, clock and reset first:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  queue can accept this cycle.
- in_inst  in  48  instruction word: [2:0] class, [3] immediate flag, [7:4] opcode, [11:8] and [15:12] register fields, [47:16] immediate.
- alu_en  out  1  ALU enable.
- alu_inst  out  48  instruction presented to the ALU.
- alu_done  in  1  ALU completion, sampled on the same cycle as alu_en.
- count  out  4  occupied entries.
- busy  out  1  queue non-empty or issue in progress.
- drop  out  1  one-cycle pulse when a non-ALU word is discarded.
- err  out  1  sticky timeout flag.
- issued  out  16  completed-issue counter; present only under ALU_ISSUE_STATS_EN.

Function
REQ-005 A word SHALL be accepted on a rising edge when in_valid=1 and in_ready=1.
REQ-006 in_ready SHALL equal (count < DEPTH); it SHALL NOT depend combinationally on alu_done.
REQ-007 An accepted word with in_inst[2:0]=3'b100 SHALL be written at the tail; any other class SHALL be discarded without writing, and drop SHALL be 1 in the following cycle.
REQ-008 The queue SHALL be a circular FIFO with head and tail pointers that wrap modulo DEPTH; order of issue SHALL equal order of acceptance.
REQ-009 The FSM SHALL have the states IDLE, ISSUE and WAIT.
REQ-010 IDLE: alu_en=0; the FSM SHALL go to ISSUE on the next edge if count > 0.
REQ-011 ISSUE and WAIT: alu_en=1 and alu_inst=head entry; alu_inst SHALL be held stable for the whole time alu_en=1.
REQ-012 ISSUE or WAIT with alu_done=1: the head SHALL be popped at the edge; the FSM SHALL go to ISSUE if count after the pop > 0, otherwise to IDLE. This gives back-to-back issue at one instruction per cycle.
REQ-013 ISSUE with alu_done=0: the FSM SHALL go to WAIT and the wait counter SHALL be loaded with 1.
REQ-014 WAIT with alu_done=0: the wait counter SHALL increment; when it reaches TIMEOUT, the head SHALL be popped, err SHALL be set, and the FSM SHALL go to IDLE.
REQ-015 A push and a pop on the same edge SHALL leave count unchanged; a push to a full queue SHALL be impossible because in_ready=0. A push to an empty queue SHALL appear at alu_inst no earlier than 2 cycles after acceptance (IDLE->ISSUE).
REQ-016 busy SHALL equal (count != 0) or (state != IDLE).
REQ-017 When alu_en=0, alu_inst SHALL be driven to 48'h0.

Reset
REQ-018 While rst=0 the block SHALL force: state=IDLE, head=tail=0, count=0, in_ready=0, alu_en=0, alu_inst=0, drop=0, err=0, wait counter=0, and issued=0 when present.
REQ-019 in_ready SHALL return to 1 in the first cycle after rst rises.
REQ-020 Reset asserted during ISSUE or WAIT SHALL abandon the in-flight instruction, and alu_en SHALL fall immediately without waiting for a clock edge.
REQ-021 Queue entry storage SHALL NOT require reset.

Configuration
REQ-022 With ALU_ISSUE_STATS_EN defined, the issued port SHALL exist and SHALL increment by 1 on each pop caused by alu_done=1 (not on timeout pops), saturating at 16'hFFFF.
REQ-023 Without ALU_ISSUE_STATS_EN, the issued port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-024 Reset, then push 48'h0000_0005_2184 with alu_done tied to 1 -> alu_en=1 with that word exactly 2 cycles after acceptance, for one cycle; count returns to 0; issued=1.
REQ-025 Push 5 ALU words back-to-back with DEPTH=4 and alu_done=0 -> in_ready=0 after the 4th word; the 5th word is held off until the first pop.
REQ-026 alu_done=1 continuously with 8 words streamed in -> alu_en stays high for 8 consecutive cycles, words issue in order, and the pointers wrap correctly.
REQ-027 Push 48'h0000_0000_0003 (class not ALU) -> not queued; drop=1 for one cycle; count=0.
REQ-028 TIMEOUT=3 with alu_done held 0 -> the head is popped in WAIT once the wait counter reaches 3, err=1 and stays 1 until reset, and the next entry issues afterwards.
REQ-029 Assert rst low mid-WAIT with 3 entries queued -> alu_en=0 asynchronously, count=0, err=0; after release, a new push issues normally.
